// File: rtl/global_mem_arbiter_pkg.sv
// Shared constants and small helpers for the global memory arbiter.
// No timing of its own; pure elaboration-time definitions.
// No flow control here; see global_mem_arbiter for the handshake.
package global_mem_arbiter_pkg;

    // Default build sizing for the global memory and its requesters.
    localparam int GMEM_NUM_REQ    = 2;
    localparam int GMEM_ADDR_WIDTH = 8;
    localparam int GMEM_DATA_WIDTH = 32;
    localparam int GMEM_DEPTH      = 256;

    // Pointer width for a round-robin over n requesters (never zero).
    function automatic int gmem_ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Requester that gets first priority after idx has been served.
    function automatic int gmem_rr_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/global_mem_arbiter_if.sv
// Requester-side handshake plus the global memory port bundle.
// Wires only; no latency.
// slave = arbiter view, master = requesters/memory view.
interface global_mem_arbiter_if
    import global_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = GMEM_NUM_REQ,
    parameter int ADDR_WIDTH = GMEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = GMEM_DATA_WIDTH
) ();
    logic [NUM_REQ-1:0]            req_vld;
    logic [NUM_REQ-1:0]            req_rdy;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            rsp_vld;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic [ADDR_WIDTH-1:0]         mem_rd_addr;
    logic [DATA_WIDTH-1:0]         mem_rd_data;
    logic                          mem_we;
    logic [ADDR_WIDTH-1:0]         mem_wr_addr;
    logic [DATA_WIDTH-1:0]         mem_wr_data;
    logic                          err_oob;

    modport slave (
        input  req_vld, req_we, req_addr, req_wdata, mem_rd_data,
        output req_rdy, rsp_vld, rsp_data, mem_rd_addr, mem_we,
               mem_wr_addr, mem_wr_data, err_oob
    );

    modport master (
        output req_vld, req_we, req_addr, req_wdata, mem_rd_data,
        input  req_rdy, rsp_vld, rsp_data, mem_rd_addr, mem_we,
               mem_wr_addr, mem_wr_data, err_oob
    );
endinterface

// File: rtl/global_mem_arbiter_rr_arbiter.sv
// Round-robin pick: first requester at or above ptr (wrapping) wins.
// Purely combinational, zero latency.
// No backpressure; gnt is zero when nobody requests.
module global_mem_arbiter_rr_arbiter
    import global_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ = GMEM_NUM_REQ,
    parameter int PTR_W   = gmem_ptr_width(GMEM_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   gnt_idx,
    output logic               gnt_any
);
    logic [PTR_W-1:0] cidx;

    // Scan the request vector from ptr upward; the first set bit wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cidx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cidx = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (!gnt_any && req[cidx]) begin
                gnt[cidx] = 1'b1;
                gnt_idx   = cidx;
                gnt_any   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/global_mem_arbiter.sv
// Round-robin share of global memory between NUM_REQ requesters (GMEM_BOUNDS_CHECK_EN adds range check).
// Writes land at the next edge; read data returns exactly 1 cycle after grant.
// Only arbitration stalls a requester; the memory accepts one transfer every cycle.
module global_mem_arbiter
    import global_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = GMEM_NUM_REQ,
    parameter int ADDR_WIDTH = GMEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = GMEM_DATA_WIDTH,
    parameter int DEPTH      = GMEM_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    global_mem_arbiter_if.slave bus
);
    localparam int PTR_W = gmem_ptr_width(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
        $error("global_mem_arbiter: NUM_REQ must be 2..4");
    end
    if (DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("global_mem_arbiter: DEPTH must fit in ADDR_WIDTH");
    end

    logic [PTR_W-1:0]      rr_ptr;
    logic [NUM_REQ-1:0]    gnt;
    logic [PTR_W-1:0]      gnt_idx;
    logic                  gnt_any;
    logic [PTR_W-1:0]      sel_idx;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_we;
    logic                  rd_xfer;
    logic                  wr_xfer;
    logic                  oob;
    logic [NUM_REQ-1:0]    rsp_vld_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  err_oob_q;

    global_mem_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req     (bus.req_vld),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // With no grant the mux parks on rr_ptr's requester so the read address stays quiet.
    assign sel_idx   = gnt_any ? gnt_idx : rr_ptr;
    assign sel_addr  = bus.req_addr[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_wdata = bus.req_wdata[sel_idx*DATA_WIDTH +: DATA_WIDTH];
    assign sel_we    = bus.req_we[sel_idx];

    assign rd_xfer = gnt_any && !sel_we;
    assign wr_xfer = gnt_any && sel_we;

`ifdef GMEM_BOUNDS_CHECK_EN
    // Out-of-range requests are still accepted but must not touch memory.
    assign oob = gnt_any && (32'(sel_addr) >= 32'(DEPTH));
`else
    assign oob = 1'b0;
`endif

    assign bus.req_rdy     = gnt;
    assign bus.mem_rd_addr = sel_addr;
    assign bus.mem_we      = wr_xfer && !rst && !oob;
    assign bus.mem_wr_addr = sel_addr;
    assign bus.mem_wr_data = sel_wdata;
    assign bus.rsp_vld     = rsp_vld_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.err_oob     = err_oob_q;

    // Pointer advance past the winner, read-response capture and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            rsp_vld_q  <= '0;
            rsp_data_q <= '0;
            err_oob_q  <= 1'b0;
        end else begin
            if (gnt_any) begin
                rr_ptr <= PTR_W'(gmem_rr_next(int'(gnt_idx), NUM_REQ));
            end
            rsp_vld_q <= rd_xfer ? gnt : '0;
            if (rd_xfer) begin
                rsp_data_q <= oob ? '0 : bus.mem_rd_data;
            end
            err_oob_q <= oob;
        end
    end
endmodule

// File: tb/tb_global_mem_arbiter.sv
// Randomized plus directed bench for global_mem_arbiter against a queue-free integer model.
// One transfer per cycle; responses checked one cycle after each read grant.
// Requesters hold their request stable until granted.
module tb_global_mem_arbiter;
    localparam int NREQ      = 2;
    localparam int AW        = 5;
    localparam int DW        = 8;
    localparam int DEPTH     = 16;
    localparam int MEM_WORDS = 1 << AW;

    logic clk;
    logic rst;
    logic preload;

    global_mem_arbiter_if #(.NUM_REQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    global_mem_arbiter #(
        .NUM_REQ    (NREQ),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input int i);
        return DW'(i * 37 + 11);
    endfunction

    // Stand-in for global_mem: combinational read, write at the clock edge.
    logic [DW-1:0] gmem [MEM_WORDS];
    assign bus.mem_rd_data = gmem[bus.mem_rd_addr];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < MEM_WORDS; i++) gmem[i] <= init_word(i);
        end else if (bus.mem_we) begin
            gmem[bus.mem_wr_addr] <= bus.mem_wr_data;
        end
    end

    // Per-requester stimulus, packed onto the flattened buses.
    logic [NREQ-1:0] p_vld;
    logic [NREQ-1:0] p_we;
    logic [AW-1:0]   p_addr  [NREQ];
    logic [DW-1:0]   p_wdata [NREQ];

    always_comb begin
        bus.req_vld   = p_vld;
        bus.req_we    = p_we;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_addr[i*AW +: AW]  = p_addr[i];
            bus.req_wdata[i*DW +: DW] = p_wdata[i];
        end
    end

    // Reference model state.
    int              ref_ptr;
    logic [DW-1:0]   ref_mem [MEM_WORDS];
    logic [NREQ-1:0] exp_rsp_vld;
    logic [DW-1:0]   exp_rsp_data;
    logic            exp_err;
    int              waits [NREQ];
    int              last_win;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Entered at a falling edge: check registered outputs, apply inputs, check the
    // combinational side, advance the model, then wait for the next falling edge.
    task automatic run_cycle(input bit r);
        int   win;
        bit   oob;
        bit   we_exp;
        check_eq("rsp_vld",  32'(bus.rsp_vld),  32'(exp_rsp_vld));
        check_eq("rsp_data", 32'(bus.rsp_data), 32'(exp_rsp_data));
        check_eq("err_oob",  32'(bus.err_oob),  32'(exp_err));
        rst = r;
        #1;
        win = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (win < 0 && p_vld[(ref_ptr + k) % NREQ]) win = (ref_ptr + k) % NREQ;
        end
        oob = 1'b0;
`ifdef GMEM_BOUNDS_CHECK_EN
        if (win >= 0) oob = (int'(p_addr[win]) >= DEPTH);
`endif
        if (!r) check_eq("req_rdy", 32'(bus.req_rdy), (win >= 0) ? (32'd1 << win) : 32'd0);
        we_exp = (win >= 0) && p_we[win] && !r && !oob;
        check_eq("mem_we", 32'(bus.mem_we), 32'(we_exp));
        if (we_exp) begin
            check_eq("mem_wr_addr", 32'(bus.mem_wr_addr), 32'(p_addr[win]));
            check_eq("mem_wr_data", 32'(bus.mem_wr_data), 32'(p_wdata[win]));
        end
        if (win >= 0 && !p_we[win]) check_eq("mem_rd_addr", 32'(bus.mem_rd_addr), 32'(p_addr[win]));
        for (int i = 0; i < NREQ; i++) begin
            if (r || !p_vld[i]) waits[i] = 0;
            else if (win == i) begin
                check_eq("wait_bound", 32'(waits[i] <= NREQ - 1), 32'd1);
                waits[i] = 0;
            end else waits[i]++;
        end
        if (r) begin
            ref_ptr      = 0;
            exp_rsp_vld  = '0;
            exp_rsp_data = '0;
            exp_err      = 1'b0;
        end else begin
            exp_rsp_vld = '0;
            if (win >= 0) begin
                ref_ptr = (win + 1) % NREQ;
                if (!p_we[win]) begin
                    exp_rsp_vld  = NREQ'(1) << win;
                    exp_rsp_data = oob ? '0 : ref_mem[p_addr[win]];
                end else if (!oob) begin
                    ref_mem[p_addr[win]] = p_wdata[win];
                end
            end
            exp_err = oob;
        end
        last_win = win;
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input bit we, input int addr, input int wdata);
        p_vld[i]   = 1'b1;
        p_we[i]    = we;
        p_addr[i]  = AW'(addr);
        p_wdata[i] = DW'(wdata);
    endtask

    int order [4];

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);
        for (int i = 0; i < NREQ; i++) begin
            p_addr[i]  = '0;
            p_wdata[i] = '0;
            waits[i]   = 0;
        end
        p_vld = '0;
        p_we  = '0;
        rst = 1'b1;
        preload = 1'b1;
        ref_ptr = 0;
        exp_rsp_vld = '0;
        exp_rsp_data = '0;
        exp_err = 1'b0;
        last_win = -1;
        @(negedge clk);
        preload = 1'b0;
        run_cycle(1'b1);
        run_cycle(1'b0);   // idle after reset: outputs at reset values, no grant

        // Single write then read-back of the same address.
        set_req(0, 1'b1, 5, 'hA5);
        run_cycle(1'b0);
        set_req(0, 1'b0, 5, 0);
        run_cycle(1'b0);
        p_vld = '0;
        check_eq("readback_vld",  32'(bus.rsp_vld),  32'd1);
        check_eq("readback_data", 32'(bus.rsp_data), 32'hA5);

        // Contention from a fresh pointer: grants alternate 0,1,0,1.
        run_cycle(1'b1);
        set_req(0, 1'b0, 1, 0);
        set_req(1, 1'b0, 2, 0);
        for (int c = 0; c < 4; c++) begin
            run_cycle(1'b0);
            order[c] = last_win;
        end
        p_vld = '0;
        check_eq("order0", 32'(order[0]), 32'd0);
        check_eq("order1", 32'(order[1]), 32'd1);
        check_eq("order2", 32'(order[2]), 32'd0);
        check_eq("order3", 32'(order[3]), 32'd1);

        // Fairness: req1 always valid, req0 raises every other cycle.
        for (int c = 0; c < 16; c++) begin
            if (!p_vld[0] && (c % 2 == 0)) set_req(0, 1'b0, $urandom_range(7, 0), 0);
            if (!p_vld[1]) set_req(1, $urandom_range(1, 0), $urandom_range(7, 0), $urandom);
            run_cycle(1'b0);
            if (last_win >= 0) p_vld[last_win] = 1'b0;
        end
        p_vld = '0;
        run_cycle(1'b0);

        // Reset while a read is being granted: response dropped, pointer back to 0.
        set_req(0, 1'b0, 3, 0);
        run_cycle(1'b1);
        p_vld = '0;
        run_cycle(1'b0);
        check_eq("rst_drop_vld", 32'(bus.rsp_vld), 32'd0);
        set_req(0, 1'b0, 6, 0);
        set_req(1, 1'b0, 7, 0);
        run_cycle(1'b0);
        check_eq("rst_ptr_zero", 32'(last_win), 32'd0);
        p_vld = '0;
        set_req(1, 1'b0, 7, 0);
        run_cycle(1'b0);
        check_eq("req1_alone", 32'(last_win), 32'd1);
        p_vld = '0;

        // Address beyond DEPTH, then read-backs of addr 4 and addr 20.
        set_req(0, 1'b1, 20, 'h3C);
        run_cycle(1'b0);
        p_vld = '0;
`ifdef GMEM_BOUNDS_CHECK_EN
        check_eq("oob_pulse", 32'(bus.err_oob), 32'd1);
`else
        check_eq("oob_pulse", 32'(bus.err_oob), 32'd0);
`endif
        set_req(1, 1'b0, 4, 0);
        run_cycle(1'b0);
        p_vld = '0;
        check_eq("addr4_intact", 32'(bus.rsp_data), 32'(init_word(4)));
        set_req(0, 1'b0, 20, 0);
        run_cycle(1'b0);
        p_vld = '0;

        // Random traffic with occasional resets, biased toward a few hot addresses.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!p_vld[i] && $urandom_range(1, 0) == 1) begin
                    set_req(i, $urandom_range(1, 0),
                            ($urandom_range(3, 0) == 0) ? $urandom_range(MEM_WORDS - 1, 0)
                                                        : $urandom_range(7, 0),
                            $urandom);
                end
            end
            run_cycle($urandom_range(49, 0) == 0);
            if (last_win >= 0) p_vld[last_win] = 1'b0;
        end
        p_vld = '0;
        run_cycle(1'b0);
        run_cycle(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
